// File: rtl/fetch_queue_if.sv
// Memory-port and decoder-side signal bundle for the sequential instruction fetch queue.
// master = the fetch queue itself, slave = the memory/decoder environment.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          mem_valid;
    logic          mem_instr;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;
    logic          fetcher_valid;
    logic          decoder_ready;
    logic [31:0]   instr;
    logic [31:0]   fetcher_pc;
    logic          flush;
    logic [31:0]   flush_pc;
    logic [CW-1:0] count;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output fetcher_valid, instr, fetcher_pc, count,
        input  mem_ready, mem_rdata, decoder_ready, flush, flush_pc
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  fetcher_valid, instr, fetcher_pc, count,
        output mem_ready, mem_rdata, decoder_ready, flush, flush_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher: keeps one memory request in flight and buffers
// returned words in a DEPTH-entry show-ahead queue with a one-cycle redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.master bus
);
    localparam int unsigned  PW   = $clog2(DEPTH);
    localparam int unsigned  CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // ST_DROP: a request is in flight whose response belongs to a flushed stream
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DROP = 2'b10
    } state_t;

    state_t        state_r, state_s;
    logic [31:0]   mem_addr_r, mem_addr_s;
    logic [31:0]   fetch_pc_r, fetch_pc_s;
    logic [PW-1:0] head_r, head_s;
    logic [PW-1:0] tail_r, tail_s;
    logic [CW-1:0] count_r, count_s;
    logic          fetcher_valid_r;
    logic [31:0]   entry_instr_r [DEPTH];
    logic [31:0]   entry_pc_r    [DEPTH];
    logic          complete_s, push_s, pop_s, start_s;

    // Queue bookkeeping, redirect target and request sequencing
    always_comb begin
        complete_s = (state_r != ST_IDLE) && bus.mem_ready;
        push_s     = complete_s && (state_r == ST_REQ) && !bus.flush;
        pop_s      = fetcher_valid_r && bus.decoder_ready && !bus.flush;

        if (bus.flush) begin
            head_s  = {PW{1'b0}};
            tail_s  = {PW{1'b0}};
            count_s = {CW{1'b0}};
        end else begin
            head_s  = head_r + PW'(pop_s);
            tail_s  = tail_r + PW'(push_s);
            count_s = count_r + CW'(push_s) - CW'(pop_s);
        end

        if (bus.flush) begin
            fetch_pc_s = {bus.flush_pc[31:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_s = mem_addr_r + 32'(PC_STEP);
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        // A request is only started when the slot for its word is guaranteed
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.flush || (count_r < FULL)) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (complete_s) begin
                    if (bus.flush || (count_s < FULL)) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (bus.flush) begin
                    state_s = ST_DROP;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DROP: begin
                if (complete_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // The address only moves when a fresh request begins, never mid-request
        start_s = (state_s == ST_REQ) && ((state_r == ST_IDLE) || complete_s);
        if (start_s) begin
            mem_addr_s = fetch_pc_s;
        end else begin
            mem_addr_s = mem_addr_r;
        end
    end

    // Control state, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            mem_addr_r      <= RESET_PC;
            fetch_pc_r      <= RESET_PC;
            head_r          <= {PW{1'b0}};
            tail_r          <= {PW{1'b0}};
            count_r         <= {CW{1'b0}};
            fetcher_valid_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            mem_addr_r      <= mem_addr_s;
            fetch_pc_r      <= fetch_pc_s;
            head_r          <= head_s;
            tail_r          <= tail_s;
            count_r         <= count_s;
            fetcher_valid_r <= (count_s != {CW{1'b0}});
        end
    end

    // Queue storage, written at the tail on each accepted response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_instr_r[i] <= 32'h0000_0000;
                entry_pc_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            entry_instr_r[tail_r] <= bus.mem_rdata;
            entry_pc_r[tail_r]    <= mem_addr_r;
        end
    end

    assign bus.mem_valid     = (state_r != ST_IDLE);
    assign bus.mem_instr     = (state_r != ST_IDLE);
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_wdata     = 32'h0000_0000;
    assign bus.mem_wstrb     = 4'h0;
    assign bus.fetcher_valid = fetcher_valid_r;
    assign bus.instr         = entry_instr_r[head_r];
    assign bus.fetcher_pc    = entry_pc_r[head_r];
    assign bus.count         = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios followed by a randomized run checked against a queue-based model.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory returns a word derived from the requested address
    assign bus.mem_rdata = bus.mem_addr ^ XMASK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, "_mem_instr"}, 32'(bus.mem_instr), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h0000_0000);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0000_0000);
        check({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        check({tag, "_fv"}, 32'(bus.fetcher_valid), 32'd0);
        check({tag, "_instr"}, bus.instr, 32'h0000_0000);
        check({tag, "_pc"}, bus.fetcher_pc, 32'h0000_0000);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
    endtask

    // reference model state for the randomized phase
    logic [31:0] exp_q[$];
    logic [31:0] m_next;
    logic        m_drop;
    logic        prev_inflight;
    logic [31:0] held_addr;
    logic        exp_mv;
    logic        have_exp;

    initial begin
        int waited;
        int size_b;
        logic pop;
        logic compl;

        checks            = 0;
        failures          = 0;
        reset             = 1'b1;
        bus.mem_ready     = 1'b0;
        bus.decoder_ready = 1'b0;
        bus.flush         = 1'b0;
        bus.flush_pc      = 32'h0000_0000;

        // reset state
        @(negedge clk);
        check_reset_values("rst");

        // zero-wait memory, streaming decoder
        reset             = 1'b0;
        bus.mem_ready     = 1'b1;
        bus.decoder_ready = 1'b1;
        @(negedge clk);
        check("t1_first_mv", 32'(bus.mem_valid), 32'd1);
        check("t1_first_addr", bus.mem_addr, 32'h0000_0000);
        check("t1_first_fv", 32'(bus.fetcher_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t1_fv", 32'(bus.fetcher_valid), 32'd1);
            check("t1_pc", bus.fetcher_pc, 32'(4 * k));
            check("t1_instr", bus.instr, 32'(4 * k) ^ XMASK);
            check("t1_addr", bus.mem_addr, 32'(4 * k + 4));
            check("t1_count", 32'(bus.count), 32'd1);
        end

        // stalled decoder fills the queue
        bus.flush         = 1'b1;
        bus.flush_pc      = 32'h0000_0000;
        bus.decoder_ready = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        check("t2_flush_count", 32'(bus.count), 32'd0);
        check("t2_flush_addr", bus.mem_addr, 32'h0000_0000);
        repeat (4) @(negedge clk);
        check("t2_full_count", 32'(bus.count), 32'd4);
        check("t2_full_mv", 32'(bus.mem_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("t2_hold_count", 32'(bus.count), 32'd4);
        check("t2_hold_pc", bus.fetcher_pc, 32'h0000_0000);
        check("t2_hold_instr", bus.instr, XMASK);
        bus.decoder_ready = 1'b1;
        @(negedge clk);
        bus.decoder_ready = 1'b0;
        check("t2_pop_count", 32'(bus.count), 32'd3);
        check("t2_pop_pc", bus.fetcher_pc, 32'h0000_0004);
        waited = 0;
        while (!bus.mem_valid && waited < 3) begin
            @(negedge clk);
            waited++;
        end
        check("t2_refetch_mv", 32'(bus.mem_valid), 32'd1);
        check("t2_refetch_addr", bus.mem_addr, 32'h0000_0010);
        @(negedge clk);
        check("t2_refill_count", 32'(bus.count), 32'd4);
        check("t2_refill_mv", 32'(bus.mem_valid), 32'd0);

        // slow memory, redirect while a request waits
        bus.mem_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'h0000_0000;
        @(negedge clk);
        bus.flush = 1'b0;
        check("t3_w1_addr", bus.mem_addr, 32'h0000_0000);
        check("t3_w1_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0102;
        check("t3_w2_addr", bus.mem_addr, 32'h0000_0000);
        @(negedge clk);
        bus.flush = 1'b0;
        check("t3_w3_mv", 32'(bus.mem_valid), 32'd1);
        check("t3_w3_addr", bus.mem_addr, 32'h0000_0000);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        check("t3_done_addr", bus.mem_addr, 32'h0000_0000);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("t3_new_mv", 32'(bus.mem_valid), 32'd1);
        check("t3_new_addr", bus.mem_addr, 32'h0000_0100);
        check("t3_stale_count", 32'(bus.count), 32'd0);
        check("t3_stale_fv", 32'(bus.fetcher_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t3_head_fv", 32'(bus.fetcher_valid), 32'd1);
        check("t3_head_pc", bus.fetcher_pc, 32'h0000_0100);
        check("t3_head_instr", bus.instr, 32'h0000_0100 ^ XMASK);

        // flush colliding with push and pop at count 2
        waited = 0;
        while (bus.count != 3'd2 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("t4_pre_count", 32'(bus.count), 32'd2);
        check("t4_pre_mv", 32'(bus.mem_valid), 32'd1);
        bus.decoder_ready = 1'b1;
        bus.flush         = 1'b1;
        bus.flush_pc      = 32'h0000_0200;
        @(negedge clk);
        bus.flush         = 1'b0;
        bus.decoder_ready = 1'b0;
        check("t4_count", 32'(bus.count), 32'd0);
        check("t4_fv", 32'(bus.fetcher_valid), 32'd0);
        check("t4_addr", bus.mem_addr, 32'h0000_0200);
        @(negedge clk);
        check("t4_head_fv", 32'(bus.fetcher_valid), 32'd1);
        check("t4_head_pc", bus.fetcher_pc, 32'h0000_0200);
        check("t4_head_count", 32'(bus.count), 32'd1);

        // asynchronous reset in the middle of a request
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("t5_inflight_mv", 32'(bus.mem_valid), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_values("t5_async");
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("t5_restart_mv", 32'(bus.mem_valid), 32'd1);
        check("t5_restart_addr", bus.mem_addr, 32'h0000_0000);
        check("t5_restart_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        check("t5_first_count", 32'(bus.count), 32'd1);
        check("t5_first_pc", bus.fetcher_pc, 32'h0000_0000);

        // randomized traffic against the reference model
        reset             = 1'b1;
        bus.mem_ready     = 1'b0;
        bus.decoder_ready = 1'b0;
        bus.flush         = 1'b0;
        @(negedge clk);
        reset         = 1'b0;
        exp_q.delete();
        m_next        = 32'h0000_0000;
        m_drop        = 1'b0;
        prev_inflight = 1'b0;
        held_addr     = 32'h0000_0000;
        exp_mv        = 1'b0;
        have_exp      = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            size_b = exp_q.size();
            check("r_count", 32'(bus.count), 32'(size_b));
            check("r_fv", 32'(bus.fetcher_valid), 32'(size_b != 0));
            if (size_b != 0) begin
                check("r_pc", bus.fetcher_pc, exp_q[0]);
                check("r_instr", bus.instr, exp_q[0] ^ XMASK);
            end
            if (have_exp) check("r_mv_rule", 32'(bus.mem_valid), 32'(exp_mv));
            if (bus.mem_valid) begin
                if (prev_inflight) begin
                    check("r_addr_hold", bus.mem_addr, held_addr);
                end else begin
                    check("r_addr_seq", bus.mem_addr, m_next);
                    check("r_slot_free", 32'(size_b < int'(DEPTH)), 32'd1);
                end
            end

            bus.mem_ready     = ($urandom_range(0, 2) != 0);
            bus.decoder_ready = ($urandom_range(0, 1) != 0);
            bus.flush         = ($urandom_range(0, 15) == 0);
            bus.flush_pc      = $urandom;

            pop   = (size_b != 0) && bus.decoder_ready;
            compl = bus.mem_valid && bus.mem_ready;
            if (!bus.mem_valid)            exp_mv = bus.flush || (size_b < int'(DEPTH));
            else if (!bus.mem_ready)       exp_mv = 1'b1;
            else if (bus.flush || m_drop)  exp_mv = 1'b1;
            else                           exp_mv = (size_b + 1 - int'(pop)) < int'(DEPTH);
            have_exp = 1'b1;

            if (bus.flush) begin
                exp_q.delete();
                m_next = {bus.flush_pc[31:2], 2'b00};
                if (bus.mem_valid && !bus.mem_ready) m_drop = 1'b1;
                else if (compl)                      m_drop = 1'b0;
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (compl) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        exp_q.push_back(bus.mem_addr);
                        m_next = bus.mem_addr + 32'd4;
                    end
                end
            end
            prev_inflight = bus.mem_valid && !bus.mem_ready;
            held_addr     = bus.mem_addr;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
